// File: rtl/rca_seq_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice width.
package rca_seq_adder_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca4_slice.sv
// Purely combinational 4-bit ripple-carry adder slice.
module rca4_slice
    import rca_seq_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               Cout
);

    logic [SLICE_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        assign s[i]     = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign Cout = w_c[SLICE_W];

endmodule

// File: rtl/rca_seq_adder.sv
// Multi-cycle WIDTH-bit adder that feeds one nibble per cycle through a single
// 4-bit ripple-carry slice, with valid/ready handshakes on both sides.
module rca_seq_adder
    import rca_seq_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_width_check
        $error("rca_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             r_state;
    state_t             w_state_d;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic [SLICE_W-1:0]       w_s;
    logic                     w_cout;
    logic [WIDTH+SLICE_W-1:0] w_sum_cat;

    rca4_slice u_slice (
        .A    (r_a_sh[SLICE_W-1:0]),
        .B    (r_b_sh[SLICE_W-1:0]),
        .cin  (r_carry),
        .s    (w_s),
        .Cout (w_cout)
    );

    // New nibble enters at the top; concatenation keeps WIDTH=4 legal.
    assign w_sum_cat = {w_s, r_sum_sh};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_state_d = RUN;
            RUN:     if (r_cnt == CNT_LAST) w_state_d = DONE;
            DONE:    if (out_ready) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> SLICE_W;
                    r_b_sh   <= r_b_sh >> SLICE_W;
                    r_sum_sh <= w_sum_cat[WIDTH+SLICE_W-1:SLICE_W];
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Result registers double as outputs; they hold until the next acceptance.
    assign sum       = r_sum_sh;
    assign cout      = r_carry;
    assign out_valid = (r_state == DONE);
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

endmodule
